// File: rtl/axi_frame_sched_if.sv
// ----------------------------------------------------------------------------
// axi_frame_sched_if
// Address-side handshake bundle between the frame burst scheduler and the
// HP0 AXI interconnect.
//   aw_valid/aw_ready/aw_addr : write address channel
//   ar_valid/ar_ready/ar_addr : read address channel
//   b_done                    : one write response accepted (BVALID&BREADY)
//   r_done                    : last read beat accepted (RVALID&RREADY&RLAST)
// master = scheduler side, slave = interconnect / data mover side.
// ----------------------------------------------------------------------------
interface axi_frame_sched_if;
    logic        aw_valid;
    logic        aw_ready;
    logic [31:0] aw_addr;
    logic        ar_valid;
    logic        ar_ready;
    logic [31:0] ar_addr;
    logic        b_done;
    logic        r_done;

    modport master (
        output aw_valid,
        output aw_addr,
        output ar_valid,
        output ar_addr,
        input  aw_ready,
        input  ar_ready,
        input  b_done,
        input  r_done
    );

    modport slave (
        input  aw_valid,
        input  aw_addr,
        input  ar_valid,
        input  ar_addr,
        output aw_ready,
        output ar_ready,
        output b_done,
        output r_done
    );
endinterface

// File: rtl/axi_frame_sched.sv
// ----------------------------------------------------------------------------
// axi_frame_sched
// Burst scheduler for the DDR frame delay path. Shares one AXI address path
// between capture (AW) and playback (AR), computes burst addresses, tracks
// outstanding bursts and rotates three frame slots on every vsync.
// Ports:
//   clk_i, rst_ni        pixel clock, async active-low reset
//   wen_i, ren_i         capture / playback enable (gate new grants only)
//   vs_i                 vsync level, rising edge = frame boundary
//   wr_level_i           beats held in the capture FIFO
//   rd_free_i            free beats in the playback FIFO
//   bus                  AW/AR handshake plus B/R completion strobes
//   wr_issue_o           1-cycle pulse after an AW is accepted
//   rd_issue_o           1-cycle pulse after an AR is accepted
//   frame_err_o          1-cycle pulse when vsync finds the write frame short
// ----------------------------------------------------------------------------
module axi_frame_sched #(
    parameter int unsigned H_WIDTH      = 1920,
    parameter int unsigned V_HEIGHT     = 1080,
    parameter logic [31:0] BASE_ADDR    = 32'h1000_0000,
    parameter logic [31:0] FRAME_STRIDE = 32'h0080_0000,
    parameter int unsigned BURST_LEN    = 16,
    parameter int unsigned MAX_OUT      = 4
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     wen_i,
    input  logic                     ren_i,
    input  logic                     vs_i,
    input  logic [9:0]               wr_level_i,
    input  logic [9:0]               rd_free_i,
    axi_frame_sched_if.master        bus,
    output logic                     wr_issue_o,
    output logic                     rd_issue_o,
    output logic                     frame_err_o
);

    localparam int unsigned CNT_W       = 17;
    localparam int unsigned OUT_W       = $clog2(MAX_OUT + 1);
    localparam int unsigned BPF         = (H_WIDTH * V_HEIGHT) / (2 * BURST_LEN);
    localparam logic [CNT_W-1:0] BPF_C  = CNT_W'(BPF);
    localparam logic [OUT_W-1:0] MAX_C  = OUT_W'(MAX_OUT);
    localparam logic [31:0] BURST_BYTES = 32'(BURST_LEN * 8);
    localparam logic [9:0]  LVL_BURST   = 10'(BURST_LEN);
    localparam logic [9:0]  LVL_URGENT  = 10'(4 * BURST_LEN);
    localparam logic [10:0] NEED_UNIT   = 11'(BURST_LEN);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_W_ADDR = 2'd1;
    localparam logic [1:0] S_R_ADDR = 2'd2;

    // Registered state
    logic [1:0]       state,      state_n;
    logic             aw_valid_q, aw_valid_n;
    logic [31:0]      aw_addr_q,  aw_addr_n;
    logic             ar_valid_q, ar_valid_n;
    logic [31:0]      ar_addr_q,  ar_addr_n;
    logic             wr_issue_q, wr_issue_n;
    logic             rd_issue_q, rd_issue_n;
    logic             frame_err_q, frame_err_n;
    logic [1:0]       wr_slot,    wr_slot_n;
    logic [1:0]       done_slot,  done_slot_n;
    logic             done_vld,   done_vld_n;
    logic [1:0]       rd_slot,    rd_slot_n;
    logic [CNT_W-1:0] wr_cnt,     wr_cnt_n;
    logic [CNT_W-1:0] rd_cnt,     rd_cnt_n;
    logic [OUT_W-1:0] wr_out,     wr_out_n;
    logic [OUT_W-1:0] rd_out,     rd_out_n;
    logic             rr,         rr_n;
    logic             pend,       pend_n;
    logic             vs_q;

    // Decode helpers
    logic             vs_rise;
    logic             w_ok;
    logic             r_ok;
    logic             urgent;
    logic             grant_w;
    logic             grant_r;
    logic             wr_acc;
    logic             rd_acc;
    logic [10:0]      rd_need;

    assign bus.aw_valid = aw_valid_q;
    assign bus.aw_addr  = aw_addr_q;
    assign bus.ar_valid = ar_valid_q;
    assign bus.ar_addr  = ar_addr_q;
    assign wr_issue_o   = wr_issue_q;
    assign rd_issue_o   = rd_issue_q;
    assign frame_err_o  = frame_err_q;

    // DDR byte address of burst 'cnt' within frame slot 'slot' (32-bit wrap)
    function automatic logic [31:0] burst_addr(input logic [1:0] slot,
                                               input logic [CNT_W-1:0] cnt);
        burst_addr = BASE_ADDR + (32'(slot) * FRAME_STRIDE) + (32'(cnt) * BURST_BYTES);
    endfunction

    // Lowest slot index that is neither of the two slots in use
    function automatic logic [1:0] pick_slot(input logic [1:0] a, input logic [1:0] b);
        if ((a != 2'd0) && (b != 2'd0)) begin
            pick_slot = 2'd0;
        end else if ((a != 2'd1) && (b != 2'd1)) begin
            pick_slot = 2'd1;
        end else begin
            pick_slot = 2'd2;
        end
    endfunction

    // Eligibility and arbitration
    always_comb begin
        vs_rise = vs_i & ~vs_q;
        rd_need = NEED_UNIT * (11'(rd_out) + 11'd1);
        w_ok    = wen_i & (wr_level_i >= LVL_BURST) & (wr_out < MAX_C)
                & (wr_cnt < BPF_C) & ~pend;
        r_ok    = ren_i & done_vld & ({1'b0, rd_free_i} >= rd_need)
                & (rd_cnt < BPF_C) & ~pend;
        urgent  = wr_level_i >= LVL_URGENT;
        grant_w = w_ok & (~r_ok | ~rr | urgent);
        grant_r = r_ok & ~grant_w;
        wr_acc  = (state == S_W_ADDR) & bus.aw_ready;
        rd_acc  = (state == S_R_ADDR) & bus.ar_ready;
    end

    // Next-state and registered-output logic
    always_comb begin
        state_n     = state;
        aw_valid_n  = aw_valid_q;
        aw_addr_n   = aw_addr_q;
        ar_valid_n  = ar_valid_q;
        ar_addr_n   = ar_addr_q;
        wr_issue_n  = wr_acc;
        rd_issue_n  = rd_acc;
        frame_err_n = 1'b0;
        wr_slot_n   = wr_slot;
        done_slot_n = done_slot;
        done_vld_n  = done_vld;
        rd_slot_n   = rd_slot;
        wr_cnt_n    = wr_cnt;
        rd_cnt_n    = rd_cnt;
        rr_n        = rr;
        // A rising edge seen while pend is already set is simply absorbed
        pend_n      = pend | vs_rise;

        case (state)
            S_IDLE: begin
                if (pend) begin
                    // Frame boundary: rotate slots and restart both counters
                    if (wr_cnt == BPF_C) begin
                        done_slot_n = wr_slot;
                        done_vld_n  = 1'b1;
                    end else begin
                        frame_err_n = 1'b1;
                    end
                    rd_slot_n = done_slot_n;
                    wr_slot_n = pick_slot(done_slot_n, rd_slot);
                    wr_cnt_n  = '0;
                    rd_cnt_n  = '0;
                    pend_n    = 1'b0;
                end else if (grant_w) begin
                    state_n    = S_W_ADDR;
                    aw_valid_n = 1'b1;
                    aw_addr_n  = burst_addr(wr_slot, wr_cnt);
                    rr_n       = ~rr;
                end else if (grant_r) begin
                    state_n    = S_R_ADDR;
                    ar_valid_n = 1'b1;
                    ar_addr_n  = burst_addr(rd_slot, rd_cnt);
                    rr_n       = ~rr;
                end
            end
            S_W_ADDR: begin
                if (bus.aw_ready) begin
                    state_n    = S_IDLE;
                    aw_valid_n = 1'b0;
                    wr_cnt_n   = wr_cnt + CNT_W'(1);
                end
            end
            S_R_ADDR: begin
                if (bus.ar_ready) begin
                    state_n    = S_IDLE;
                    ar_valid_n = 1'b0;
                    rd_cnt_n   = rd_cnt + CNT_W'(1);
                end
            end
            default: begin
                state_n    = S_IDLE;
                aw_valid_n = 1'b0;
                ar_valid_n = 1'b0;
            end
        endcase
    end

    // Outstanding-burst counters: simultaneous inc/dec cancels, no underflow
    always_comb begin
        wr_out_n = wr_out;
        case ({wr_acc, bus.b_done})
            2'b10:   wr_out_n = wr_out + OUT_W'(1);
            2'b01:   if (wr_out != '0) wr_out_n = wr_out - OUT_W'(1);
            default: wr_out_n = wr_out;
        endcase

        rd_out_n = rd_out;
        case ({rd_acc, bus.r_done})
            2'b10:   rd_out_n = rd_out + OUT_W'(1);
            2'b01:   if (rd_out != '0) rd_out_n = rd_out - OUT_W'(1);
            default: rd_out_n = rd_out;
        endcase
    end

    // State register
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state       <= S_IDLE;
            aw_valid_q  <= 1'b0;
            aw_addr_q   <= '0;
            ar_valid_q  <= 1'b0;
            ar_addr_q   <= '0;
            wr_issue_q  <= 1'b0;
            rd_issue_q  <= 1'b0;
            frame_err_q <= 1'b0;
            wr_slot     <= 2'd0;
            done_slot   <= 2'd0;
            done_vld    <= 1'b0;
            rd_slot     <= 2'd0;
            wr_cnt      <= '0;
            rd_cnt      <= '0;
            wr_out      <= '0;
            rd_out      <= '0;
            rr          <= 1'b0;
            pend        <= 1'b0;
            vs_q        <= 1'b0;
        end else begin
            state       <= state_n;
            aw_valid_q  <= aw_valid_n;
            aw_addr_q   <= aw_addr_n;
            ar_valid_q  <= ar_valid_n;
            ar_addr_q   <= ar_addr_n;
            wr_issue_q  <= wr_issue_n;
            rd_issue_q  <= rd_issue_n;
            frame_err_q <= frame_err_n;
            wr_slot     <= wr_slot_n;
            done_slot   <= done_slot_n;
            done_vld    <= done_vld_n;
            rd_slot     <= rd_slot_n;
            wr_cnt      <= wr_cnt_n;
            rd_cnt      <= rd_cnt_n;
            wr_out      <= wr_out_n;
            rd_out      <= rd_out_n;
            rr          <= rr_n;
            pend        <= pend_n;
            vs_q        <= vs_i;
        end
    end

endmodule

// File: tb/tb_axi_frame_sched.sv
// ----------------------------------------------------------------------------
// tb_axi_frame_sched
// Scoreboard bench for axi_frame_sched with a reduced frame (64x4 pixels,
// 8 bursts per frame). Stimulus pushes expected AW/AR addresses; a negedge
// monitor pops and compares on every accepted address handshake.
// ----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_axi_frame_sched;

    localparam int unsigned H_W = 64;
    localparam int unsigned V_H = 4;

    logic       clk_i  = 1'b0;
    logic       rst_ni = 1'b1;
    logic       wen_i  = 1'b0;
    logic       ren_i  = 1'b0;
    logic       vs_i   = 1'b0;
    logic [9:0] wr_level_i = '0;
    logic [9:0] rd_free_i  = '0;
    logic       wr_issue_o;
    logic       rd_issue_o;
    logic       frame_err_o;

    axi_frame_sched_if bus();

    axi_frame_sched #(
        .H_WIDTH  (H_W),
        .V_HEIGHT (V_H)
    ) dut (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .wen_i       (wen_i),
        .ren_i       (ren_i),
        .vs_i        (vs_i),
        .wr_level_i  (wr_level_i),
        .rd_free_i   (rd_free_i),
        .bus         (bus),
        .wr_issue_o  (wr_issue_o),
        .rd_issue_o  (rd_issue_o),
        .frame_err_o (frame_err_o)
    );

    always #5 clk_i = ~clk_i;

    int          n_checks = 0;
    int          n_errors = 0;
    int          hs_cnt   = 0;
    int          wr_iss_cnt = 0;
    int          ferr_cnt = 0;
    logic [31:0] exp_aw[$];
    logic [31:0] exp_ar[$];
    bit          order_log[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: score every accepted address and count pulses
    always @(negedge clk_i) begin
        if (rst_ni) begin
            if (bus.aw_valid && bus.aw_ready) begin
                if (exp_aw.size() == 0) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL aw_unexpected: got %h expected none", bus.aw_addr);
                end else begin
                    check("aw_addr", bus.aw_addr, exp_aw.pop_front());
                end
                order_log.push_back(1'b1);
                hs_cnt++;
            end
            if (bus.ar_valid && bus.ar_ready) begin
                if (exp_ar.size() == 0) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL ar_unexpected: got %h expected none", bus.ar_addr);
                end else begin
                    check("ar_addr", bus.ar_addr, exp_ar.pop_front());
                end
                order_log.push_back(1'b0);
                hs_cnt++;
            end
            if (wr_issue_o)  wr_iss_cnt++;
            if (frame_err_o) ferr_cnt++;
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk_i);
        #1;
    endtask

    task automatic wait_hs(input int target, input int budget, input string name);
        int k = 0;
        while ((hs_cnt < target) && (k < budget)) begin
            step(1);
            k++;
        end
        n_checks++;
        if (hs_cnt < target) begin
            n_errors++;
            $display("FAIL %s: got %0d handshakes expected %0d", name, hs_cnt, target);
        end
    endtask

    task automatic wait_valid(input bit is_aw, input int budget, input string name);
        int k = 0;
        while (((is_aw ? bus.aw_valid : bus.ar_valid) !== 1'b1) && (k < budget)) begin
            step(1);
            k++;
        end
        check(name, 32'(is_aw ? bus.aw_valid : bus.ar_valid), 32'd1);
    endtask

    task automatic vsync_pulse();
        vs_i = 1'b1;
        step(1);
        vs_i = 1'b0;
        step(3);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int base_idx;
        bus.aw_ready = 1'b0;
        bus.ar_ready = 1'b0;
        bus.b_done   = 1'b0;
        bus.r_done   = 1'b0;

        // Reset values
        #2 rst_ni = 1'b0;
        #1;
        check("rst_aw_valid",  32'(bus.aw_valid), 32'd0);
        check("rst_ar_valid",  32'(bus.ar_valid), 32'd0);
        check("rst_aw_addr",   bus.aw_addr,       32'd0);
        check("rst_ar_addr",   bus.ar_addr,       32'd0);
        check("rst_wr_issue",  32'(wr_issue_o),   32'd0);
        check("rst_rd_issue",  32'(rd_issue_o),   32'd0);
        check("rst_frame_err", 32'(frame_err_o),  32'd0);
        step(3);
        rst_ni = 1'b1;
        step(2);

        // Reset while an AW is held pending
        wen_i = 1'b1;
        wr_level_i = 10'd16;
        wait_valid(1'b1, 10, "pre_reset_aw_valid");
        #2 rst_ni = 1'b0;
        #1;
        check("reset_async_aw_valid", 32'(bus.aw_valid), 32'd0);
        wen_i = 1'b0;
        step(2);
        rst_ni = 1'b1;
        step(2);
        check("post_reset_aw_valid", 32'(bus.aw_valid), 32'd0);

        // AW stalled by ready: valid and address hold, one issue pulse
        wen_i = 1'b1;
        wait_valid(1'b1, 10, "stall_aw_valid");
        for (int i = 0; i < 5; i++) begin
            check("stall_valid_hold", 32'(bus.aw_valid), 32'd1);
            check("stall_addr_hold",  bus.aw_addr,       32'h1000_0000);
            step(1);
        end
        wen_i = 1'b0;
        exp_aw.push_back(32'h1000_0000);
        bus.aw_ready = 1'b1;
        step(1);
        check("issue_pulse_hi", 32'(wr_issue_o),   32'd1);
        check("valid_dropped",  32'(bus.aw_valid), 32'd0);
        step(1);
        check("issue_pulse_lo", 32'(wr_issue_o),   32'd0);
        exp_aw.push_back(32'h1000_0080);
        wen_i = 1'b1;
        wait_hs(2, 10, "second_burst");
        wen_i = 1'b0;
        step(2);
        check("wr_issue_count_2", 32'(wr_iss_cnt), 32'd2);
        bus.b_done = 1'b1;
        step(3);
        bus.b_done = 1'b0;

        // Outstanding limit: four AWs, then a fifth only after one B
        for (int i = 2; i < 6; i++) exp_aw.push_back(32'h1000_0000 + 32'(i) * 32'h80);
        wr_level_i = 10'd64;
        wen_i = 1'b1;
        step(30);
        check("max_out_hs",    32'(hs_cnt),     32'd6);
        check("max_out_issue", 32'(wr_iss_cnt), 32'd6);
        exp_aw.push_back(32'h1000_0300);
        bus.b_done = 1'b1;
        step(1);
        bus.b_done = 1'b0;
        step(10);
        check("fifth_after_b", 32'(hs_cnt), 32'd7);
        wen_i = 1'b0;
        bus.b_done = 1'b1;
        step(6);
        bus.b_done = 1'b0;

        // Frame boundary: writes stop at bursts-per-frame
        exp_aw.push_back(32'h1000_0380);
        wr_level_i = 10'd16;
        wen_i = 1'b1;
        step(20);
        check("stop_at_bpf", 32'(hs_cnt), 32'd8);
        wen_i = 1'b0;
        bus.b_done = 1'b1;
        bus.r_done = 1'b1;

        // Complete frame -> slot swap, round-robin W/R alternation
        vsync_pulse();
        check("good_frame_no_err", 32'(ferr_cnt), 32'd0);
        for (int i = 0; i < 8; i++) begin
            exp_aw.push_back(32'h1080_0000 + 32'(i) * 32'h80);
            exp_ar.push_back(32'h1000_0000 + 32'(i) * 32'h80);
        end
        base_idx = order_log.size();
        rd_free_i = 10'd1023;
        bus.ar_ready = 1'b1;
        wen_i = 1'b1;
        ren_i = 1'b1;
        wait_hs(24, 60, "rr_frame");
        step(10);
        wen_i = 1'b0;
        ren_i = 1'b0;
        for (int i = 0; i < 16; i++)
            check("rr_order", 32'(order_log[base_idx + i]), ((i % 2) == 0) ? 32'd1 : 32'd0);
        check("rr_aw_drained", 32'(exp_aw.size()), 32'd0);
        check("rr_ar_drained", 32'(exp_ar.size()), 32'd0);

        // Second complete frame, then a short one -> frame error
        vsync_pulse();
        check("second_frame_no_err", 32'(ferr_cnt), 32'd0);
        for (int i = 0; i < 3; i++) exp_aw.push_back(32'h1100_0000 + 32'(i) * 32'h80);
        wen_i = 1'b1;
        wait_hs(27, 30, "partial_writes");
        wen_i = 1'b0;
        step(2);
        vsync_pulse();
        check("frame_err_pulse", 32'(ferr_cnt), 32'd1);

        // Urgent write level overrides rr (rr now favours read)
        exp_aw.push_back(32'h1000_0000);
        wr_level_i = 10'd64;
        wen_i = 1'b1;
        ren_i = 1'b1;
        wait_hs(28, 10, "urgent_grant");
        wen_i = 1'b0;
        ren_i = 1'b0;
        check("urgent_write_first", 32'(order_log[order_log.size() - 1]), 32'd1);
        step(2);

        // Normal level: rr alternation resumes, read repeats done slot 1
        exp_aw.push_back(32'h1000_0080);
        exp_ar.push_back(32'h1080_0000);
        wr_level_i = 10'd16;
        wen_i = 1'b1;
        ren_i = 1'b1;
        wait_hs(30, 20, "rr_after_err");
        wen_i = 1'b0;
        ren_i = 1'b0;
        check("rr_after_err_w", 32'(order_log[28]), 32'd1);
        check("rr_after_err_r", 32'(order_log[29]), 32'd0);
        step(2);

        // Vsync during a stalled AR: address holds, swap after acceptance
        bus.ar_ready = 1'b0;
        ren_i = 1'b1;
        wait_valid(1'b0, 10, "stall_ar_valid");
        vs_i = 1'b1;
        step(1);
        vs_i = 1'b0;
        for (int i = 0; i < 5; i++) begin
            check("ar_valid_hold", 32'(bus.ar_valid), 32'd1);
            check("ar_addr_hold",  bus.ar_addr,       32'h1080_0080);
            step(1);
        end
        exp_ar.push_back(32'h1080_0080);
        exp_ar.push_back(32'h1080_0000);
        bus.ar_ready = 1'b1;
        wait_hs(32, 20, "ar_after_vsync");
        ren_i = 1'b0;
        step(3);
        check("frame_err_after_ar", 32'(ferr_cnt), 32'd2);
        check("end_aw_drained", 32'(exp_aw.size()), 32'd0);
        check("end_ar_drained", 32'(exp_ar.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
